register_load_arbiter: RTL and testbench
========================================

Name: register_load_arbiter

Overview:
- Round-robin arbiter and load sequencer for one shared WIDTH-bit negative-edge register with an active-low load enable.
- Four requesters compete to write the register. The block selects one winner and muxes that winner's data onto DataOut.
- It pulses the register's Enbar low for exactly one cycle, then holds the grant until the winner releases its request.
- It sits between the requesting datapath blocks and the register's D/Enbar/ClkN inputs. ClkN is shared with the register.

Parameters:
WIDTH, 8, data width of the shared register and of each requester's data lane

Ports:
ClkN  input  1  clock; all state updates on the falling edge of ClkN
ClrN  input  1  reset, asynchronous, active-low; forces all state to reset values immediately
Req  input  4  request per requester, active-high, level; Req[i] belongs to requester i
Din  input  4*WIDTH  requester data, flattened; requester i at Din[i*WIDTH +: WIDTH]
Gnt  output  4  one-hot grant, active-high; all zero when no transaction is in progress
DataOut  output  WIDTH  registered data for the shared register's D input
Enbar  output  1  active-low load enable for the shared register, registered
Busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (ClrN low, any time including mid-transaction):
  - State=IDLE, Gnt=4'b0000, DataOut=0, Enbar=1, Busy=0, priority pointer ptr=0.
  - No Enbar glitch low is allowed during or after reset.
- State machine: IDLE -> LOAD -> RELEASE -> IDLE. All outputs are registered; none are decoded combinationally from Req.
- IDLE:
  - If Req==0, stay in IDLE; outputs keep their reset values, except DataOut, which holds its last value.
  - If Req!=0, pick the winner w. Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4; the first index with Req set wins.
  - At that falling edge: Gnt=onehot(w), DataOut=Din[w lane], Enbar=0, state=LOAD.
- LOAD:
  - Lasts exactly one cycle. At the next falling edge: Enbar=1, state=RELEASE.
  - Gnt and DataOut are held.
  - The shared register captures DataOut at this same edge, because Enbar was low for the preceding cycle.
- RELEASE:
  - Gnt and DataOut are held; Enbar=1.
  - When Req[w]==0 at a falling edge: Gnt=0, ptr=(w+1) mod 4, state=IDLE.
  - Other requests are ignored while in RELEASE.
- Timing:
  - Minimum transaction is 3 falling edges (grant, load, release). A new grant earliest at the 4th edge.
  - Latency from Req sampled high in IDLE to Enbar low is 1 edge. Exactly one Enbar low cycle per grant.
- Request withdrawn during LOAD: the load still completes with the latched data. RELEASE then sees Req[w]==0 and returns to IDLE on the next edge.
- Din changes after the grant edge have no effect on DataOut for that transaction.
- Requests that arrive while Busy are not queued. They are evaluated only when the state is IDLE.
- ptr only advances on completed transactions (RELEASE -> IDLE). A reset restarts priority at requester 0.
- Invariants:
  - Gnt is zero or one-hot.
  - Enbar==0 only in LOAD.
  - Busy==1 exactly when Gnt!=0.

Test Plan:
- Reset: ClrN=0 with Req=4'hF and random Din -> Gnt=0, Enbar=1, DataOut=0, Busy=0; after release, the first grant goes to requester 0.
- Single request: Req=4'b0100, Din lane2=8'hA5 -> edge1 Gnt=4'b0100, DataOut=8'hA5, Enbar=0; edge2 Enbar=1; register reads 8'hA5; Req dropped -> next edge Gnt=0, Busy=0.
- Fairness: all four Req held high, each released one cycle after its Gnt -> grant order 0,1,2,3,0; exactly one Enbar low pulse per grant.
- Priority rotation: after grant to 2 completes, Req=4'b1001 -> grant to 3 first, then 0.
- Early withdrawal: Req[1] dropped during LOAD -> Enbar still low one cycle, data 8'h3C is loaded, IDLE one edge later, ptr=2.
- Mid-transaction reset: ClrN pulsed low in LOAD -> Enbar returns to 1 immediately (asynchronously), Gnt=0; after reset, pending requests are re-arbitrated from ptr=0.

Source files
------------

// File: rtl/register_load_arbiter.sv
// Round-robin arbiter and load sequencer for one shared falling-edge register
// with an active-low load enable; grants one of four requesters per transaction.
module register_load_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 ClkN,
  input  logic                 ClrN,
  input  logic [3:0]           Req,
  input  logic [4*WIDTH-1:0]   Din,
  output logic [3:0]           Gnt,
  output logic [WIDTH-1:0]     DataOut,
  output logic                 Enbar,
  output logic                 Busy
);

  localparam int unsigned N_REQ = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_gnt, w_gnt_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_enbar, w_enbar_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [1:0]       r_win, w_win_nxt;

  logic             w_found;
  logic [1:0]       w_cand;
  logic [1:0]       w_sel;

  // Rotating-priority search starting at the pointer.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 2'd0;
    w_cand  = 2'd0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_found && Req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  // Falling-edge state register; clear is asynchronous so Enbar rises at once.
  always_ff @(negedge ClkN or negedge ClrN) begin
    if (!ClrN) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_data  <= '0;
      r_enbar <= 1'b1;
      r_ptr   <= 2'd0;
      r_win   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_data  <= w_data_nxt;
      r_enbar <= w_enbar_nxt;
      r_ptr   <= w_ptr_nxt;
      r_win   <= w_win_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_data_nxt  = r_data;
    w_enbar_nxt = 1'b1;
    w_ptr_nxt   = r_ptr;
    w_win_nxt   = r_win;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_LOAD;
          w_gnt_nxt   = 4'b0001 << w_sel;
          w_data_nxt  = Din[32'(w_sel) * WIDTH +: WIDTH];
          w_enbar_nxt = 1'b0;
          w_win_nxt   = w_sel;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!Req[r_win]) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 4'b0000;
          w_ptr_nxt   = r_win + 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase
  end

  assign Gnt     = r_gnt;
  assign DataOut = r_data;
  assign Enbar   = r_enbar;
  assign Busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_register_load_arbiter.sv
// Self-checking bench for register_load_arbiter: scoreboard of expected grants
// plus a behavioural model of the shared register loaded by Enbar.
module tb_register_load_arbiter;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [3:0]       gnt;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic               ClkN = 1'b1;
  logic               ClrN = 1'b0;
  logic [3:0]         Req  = 4'b0000;
  logic [4*WIDTH-1:0] Din  = '0;
  logic [3:0]         Gnt;
  logic [WIDTH-1:0]   DataOut;
  logic               Enbar;
  logic               Busy;

  exp_t             exp_q[$];
  exp_t             e;
  int               n_cmp = 0;
  int               n_err = 0;
  int               n_low = 0;
  logic [WIDTH-1:0] shadow = '0;

  register_load_arbiter #(.WIDTH(WIDTH)) dut (
    .ClkN    (ClkN),
    .ClrN    (ClrN),
    .Req     (Req),
    .Din     (Din),
    .Gnt     (Gnt),
    .DataOut (DataOut),
    .Enbar   (Enbar),
    .Busy    (Busy)
  );

  always #5 ClkN = ~ClkN;

  // Shared register: loads D on a falling edge when Enbar was low before it.
  always @(negedge ClkN) if (Enbar === 1'b0) shadow <= DataOut;

  // Invariants sampled mid-cycle.
  always @(posedge ClkN) begin
    if (ClrN) begin
      if (Enbar === 1'b0) n_low++;
      n_cmp++;
      if (!((Gnt & (Gnt - 4'd1)) == 4'd0 && Busy === (Gnt != 4'd0))) begin
        n_err++;
        $display("FAIL inv_gnt_busy: got Gnt=%b Busy=%b required onehot0 and Busy==|Gnt", Gnt, Busy);
      end
      n_cmp++;
      if (Enbar === 1'b0 && Busy !== 1'b1) begin
        n_err++;
        $display("FAIL inv_enbar: got Enbar=%b Busy=%b required Enbar low only while busy", Enbar, Busy);
      end
    end
  end

  task automatic tick();
    @(negedge ClkN);
    #1;
  endtask

  task automatic test_reset();
    ClrN = 1'b0;
    Req  = 4'hF;
    Din  = $urandom;
    tick();
    tick();
    n_cmp++; if (Gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b required 0000", Gnt); end
    n_cmp++; if (Enbar !== 1'b1) begin n_err++; $display("FAIL reset_enbar: got %b required 1", Enbar); end
    n_cmp++; if (DataOut !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h required 00", DataOut); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", Busy); end
    ClrN = 1'b1;
    exp_q.push_back('{gnt: 4'b0001, data: Din[7:0]});
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (Gnt !== e.gnt) begin n_err++; $display("FAIL reset_first_gnt: got %b required %b", Gnt, e.gnt); end
    n_cmp++; if (DataOut !== e.data) begin n_err++; $display("FAIL reset_first_data: got %h required %h", DataOut, e.data); end
    n_cmp++; if (Enbar !== 1'b0) begin n_err++; $display("FAIL reset_first_enbar: got %b required 0", Enbar); end
    Req = 4'b0000;
    tick();
    n_cmp++; if (Enbar !== 1'b1) begin n_err++; $display("FAIL reset_load_enbar: got %b required 1", Enbar); end
    n_cmp++; if (shadow !== e.data) begin n_err++; $display("FAIL reset_reg: got %h required %h", shadow, e.data); end
    tick();
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_done_busy: got %b required 0", Busy); end
  endtask

  task automatic test_single();
    Din = $urandom;
    Din[23:16] = 8'hA5;
    Req = 4'b0100;
    exp_q.push_back('{gnt: 4'b0100, data: 8'hA5});
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (Gnt !== e.gnt) begin n_err++; $display("FAIL single_gnt: got %b required %b", Gnt, e.gnt); end
    n_cmp++; if (DataOut !== e.data) begin n_err++; $display("FAIL single_data: got %h required %h", DataOut, e.data); end
    n_cmp++; if (Enbar !== 1'b0) begin n_err++; $display("FAIL single_enbar_low: got %b required 0", Enbar); end
    n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b required 1", Busy); end
    tick();
    n_cmp++; if (Enbar !== 1'b1) begin n_err++; $display("FAIL single_enbar_high: got %b required 1", Enbar); end
    n_cmp++; if (shadow !== e.data) begin n_err++; $display("FAIL single_reg: got %h required %h", shadow, e.data); end
    n_cmp++; if (Gnt !== e.gnt) begin n_err++; $display("FAIL single_gnt_hold: got %b required %b", Gnt, e.gnt); end
    Req = 4'b0000;
    tick();
    n_cmp++; if (Gnt !== 4'b0000) begin n_err++; $display("FAIL single_release_gnt: got %b required 0000", Gnt); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL single_release_busy: got %b required 0", Busy); end
  endtask

  task automatic test_rotation();
    Din = $urandom;
    Req = 4'b1001;
    exp_q.push_back('{gnt: 4'b1000, data: Din[31:24]});
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (Gnt !== e.gnt) begin n_err++; $display("FAIL rot_first_gnt: got %b required %b", Gnt, e.gnt); end
    n_cmp++; if (DataOut !== e.data) begin n_err++; $display("FAIL rot_first_data: got %h required %h", DataOut, e.data); end
    tick();
    Req = 4'b0001;
    tick();
    n_cmp++; if (Gnt !== 4'b0000) begin n_err++; $display("FAIL rot_idle_gnt: got %b required 0000", Gnt); end
    exp_q.push_back('{gnt: 4'b0001, data: Din[7:0]});
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (Gnt !== e.gnt) begin n_err++; $display("FAIL rot_second_gnt: got %b required %b", Gnt, e.gnt); end
    n_cmp++; if (DataOut !== e.data) begin n_err++; $display("FAIL rot_second_data: got %h required %h", DataOut, e.data); end
    Req = 4'b0000;
    tick();
    tick();
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rot_done_busy: got %b required 0", Busy); end
  endtask

  task automatic test_fairness();
    int         low0;
    logic [3:0] g;
    ClrN = 1'b0;
    #1;
    ClrN = 1'b1;
    low0 = n_low;
    Din  = $urandom;
    Req  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      g = 4'b0001 << (i % 4);
      exp_q.push_back('{gnt: g, data: Din[(i % 4) * WIDTH +: WIDTH]});
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (Gnt !== e.gnt) begin n_err++; $display("FAIL fair_gnt_%0d: got %b required %b", i, Gnt, e.gnt); end
      n_cmp++; if (DataOut !== e.data) begin n_err++; $display("FAIL fair_data_%0d: got %h required %h", i, DataOut, e.data); end
      tick();
      n_cmp++; if (shadow !== e.data) begin n_err++; $display("FAIL fair_reg_%0d: got %h required %h", i, shadow, e.data); end
      Req = Req & ~g;
      tick();
      n_cmp++; if (Gnt !== 4'b0000) begin n_err++; $display("FAIL fair_release_%0d: got %b required 0000", i, Gnt); end
      Req = (i == 4) ? 4'b0000 : 4'hF;
    end
    n_cmp++; if (n_low - low0 !== 5) begin n_err++; $display("FAIL fair_pulses: got %0d required 5", n_low - low0); end
  endtask

  task automatic test_early_withdraw();
    Din = $urandom;
    Din[15:8] = 8'h3C;
    Req = 4'b0010;
    exp_q.push_back('{gnt: 4'b0010, data: 8'h3C});
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (Gnt !== e.gnt) begin n_err++; $display("FAIL early_gnt: got %b required %b", Gnt, e.gnt); end
    n_cmp++; if (Enbar !== 1'b0) begin n_err++; $display("FAIL early_enbar_low: got %b required 0", Enbar); end
    Req = 4'b0000;
    Din[15:8] = 8'hC3;
    tick();
    n_cmp++; if (Enbar !== 1'b1) begin n_err++; $display("FAIL early_enbar_high: got %b required 1", Enbar); end
    n_cmp++; if (DataOut !== e.data) begin n_err++; $display("FAIL early_data_hold: got %h required %h", DataOut, e.data); end
    n_cmp++; if (shadow !== e.data) begin n_err++; $display("FAIL early_reg: got %h required %h", shadow, e.data); end
    n_cmp++; if (Gnt !== e.gnt) begin n_err++; $display("FAIL early_gnt_hold: got %b required %b", Gnt, e.gnt); end
    tick();
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL early_idle: got %b required 0", Busy); end
    Req = 4'hF;
    exp_q.push_back('{gnt: 4'b0100, data: Din[23:16]});
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (Gnt !== e.gnt) begin n_err++; $display("FAIL early_ptr_gnt: got %b required %b", Gnt, e.gnt); end
    Req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_mid_reset();
    logic [WIDTH-1:0] prev;
    Din = $urandom;
    Req = 4'b1110;
    exp_q.push_back('{gnt: 4'b1000, data: Din[31:24]});
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (Gnt !== e.gnt) begin n_err++; $display("FAIL midrst_pre_gnt: got %b required %b", Gnt, e.gnt); end
    n_cmp++; if (Enbar !== 1'b0) begin n_err++; $display("FAIL midrst_pre_enbar: got %b required 0", Enbar); end
    prev = shadow;
    #1;
    ClrN = 1'b0;
    #1;
    n_cmp++; if (Enbar !== 1'b1) begin n_err++; $display("FAIL midrst_enbar: got %b required 1", Enbar); end
    n_cmp++; if (Gnt !== 4'b0000) begin n_err++; $display("FAIL midrst_gnt: got %b required 0000", Gnt); end
    n_cmp++; if (DataOut !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h required 00", DataOut); end
    tick();
    tick();
    n_cmp++; if (shadow !== prev) begin n_err++; $display("FAIL midrst_reg: got %h required %h", shadow, prev); end
    ClrN = 1'b1;
    exp_q.push_back('{gnt: 4'b0010, data: Din[15:8]});
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (Gnt !== e.gnt) begin n_err++; $display("FAIL midrst_regrant: got %b required %b", Gnt, e.gnt); end
    n_cmp++; if (DataOut !== e.data) begin n_err++; $display("FAIL midrst_regrant_data: got %h required %h", DataOut, e.data); end
    Req = 4'b0000;
    tick();
    tick();
    tick();
    tick();
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL midrst_done_busy: got %b required 0", Busy); end
    n_cmp++; if (DataOut !== e.data) begin n_err++; $display("FAIL idle_data_hold: got %h required %h", DataOut, e.data); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_fairness();
    test_early_withdraw();
    test_mid_reset();
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_empty: got %0d entries required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
